// File: rtl/regbank_pkg.sv
// Shared types and constants for the multi-port register bank.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/regbank_mp_if.sv
// Write/read port bundle of regbank_mp. The master drives the write and read addresses; the slave returns the read data and the status flags.
interface regbank_mp_if import regbank_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = 2
) ();

  logic [1:0]          wr_en;
  logic [2*ADDR_W-1:0] wr_addr;
  logic [2*DATA_W-1:0] wr_data;
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic                ready;
  logic                wr_conflict;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, ready, wr_conflict
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, ready, wr_conflict
  );

endinterface

// File: rtl/regbank_init_fsm.sv
// Post-reset clear sweep. The sweep visits every address once, then signals that the bank is ready.
module regbank_init_fsm import regbank_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_en    = 1'b0;
    case (state_q)
      INIT: begin
        // The reset edge itself must leave the storage alone.
        clr_en    = !reset;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign clr_addr = clr_ptr_q;
  assign ready    = (state_q == RUN);

endmodule

// File: rtl/regbank_mp.sv
// Multi-port register bank: NRD combinational read ports, two prioritised write ports (B beats A), read-after-write bypass.
// Optional build macro ZERO_REG_EN hardwires reg[0] to zero.
module regbank_mp import regbank_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int NRD    = 2
) (
  input logic         clk,
  input logic         reset,
  regbank_mp_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;

  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [DATA_W-1:0] data_a, data_b;
  logic              wr_a, wr_b;
  logic              conflict_q, conflict_d;

  // Address that maps onto a real, writable entry.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    if ({1'b0, a} >= DEPTH_EXT) return 1'b0;
`ifdef ZERO_REG_EN
    if (a == '0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  regbank_init_fsm #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign addr_a = bus.wr_addr[PORT_A*ADDR_W +: ADDR_W];
  assign addr_b = bus.wr_addr[PORT_B*ADDR_W +: ADDR_W];
  assign data_a = bus.wr_data[PORT_A*DATA_W +: DATA_W];
  assign data_b = bus.wr_data[PORT_B*DATA_W +: DATA_W];

  assign wr_a = ready && bus.wr_en[PORT_A] && addr_ok(addr_a);
  assign wr_b = ready && bus.wr_en[PORT_B] && addr_ok(addr_b);

  assign conflict_d = wr_a && wr_b && (addr_a == addr_b);

  always_ff @(posedge clk) begin
    if (reset) conflict_q <= 1'b0;
    else       conflict_q <= conflict_d;
  end

  // Sweep clear and the two write ports never overlap: writes are gated by ready.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_en && clr_addr == ADDR_W'(i))    mem_q[i] <= '0;
      else if (wr_b && addr_b == ADDR_W'(i))   mem_q[i] <= data_b;
      else if (wr_a && addr_a == ADDR_W'(i))   mem_q[i] <= data_a;
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = bus.rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        rd = '0;
        if (ready && addr_ok(ra)) begin
          if (wr_b && addr_b == ra)      rd = data_b;
          else if (wr_a && addr_a == ra) rd = data_a;
          else                           rd = mem_q[ra];
        end
      end

      assign bus.rd_data[gi*DATA_W +: DATA_W] = rd;
    end
  endgenerate

  assign bus.ready       = ready;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_regbank_mp.sv
// Scoreboard bench for regbank_mp: two instances (DEPTH 32 and 20) share one stimulus stream and are checked against a behavioural model.
module tb_regbank_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regbank_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) if0 ();
  regbank_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD)) if1 ();

  regbank_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .NRD(NRD)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  regbank_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(20), .NRD(NRD)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  typedef struct {
    bit                    chk;
    int                    tx;
    logic                  rdy;
    logic                  conf;
    logic [NRD*DW-1:0]     rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int failures = 0;
  int n_tx = 0;

  // Reference model: plain register array per instance plus sweep progress.
  logic [DW-1:0] mem [2][32];
  int  cnt  [2];
  bit  rdy  [2];
  bit  conf [2];
  bit  known = 1'b0;

  function automatic int dep(int d);
    return (d == 0) ? 32 : 20;
  endfunction

  function automatic bit m_ok(int d, logic [AW-1:0] a);
    if (int'(a) >= dep(d)) return 1'b0;
`ifdef ZERO_REG_EN
    if (a == 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] m_read(int d, logic [1:0] we, logic [AW-1:0] aa, logic [AW-1:0] ab,
                                           logic [DW-1:0] da, logic [DW-1:0] db, logic [AW-1:0] ra);
    if (!rdy[d] || !m_ok(d, ra)) return '0;
    if (we[1] && m_ok(d, ab) && ab == ra) return db;
    if (we[0] && m_ok(d, aa) && aa == ra) return da;
    return mem[d][ra];
  endfunction

  function automatic logic [NRD*AW-1:0] ra2(int p0, int p1);
    logic [NRD*AW-1:0] r;
    r = {AW'(p1), AW'(p0)};
    return r;
  endfunction

  task automatic cycle(input bit rst, input logic [1:0] we, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                       input logic [DW-1:0] da, input logic [DW-1:0] db, input logic [NRD*AW-1:0] ra);
    exp_t e;
    bit va, vb;
    @(negedge clk);
    reset = rst;
    if0.wr_en = we; if0.wr_addr = {ab, aa}; if0.wr_data = {db, da}; if0.rd_addr = ra;
    if1.wr_en = we; if1.wr_addr = {ab, aa}; if1.wr_data = {db, da}; if1.rd_addr = ra;
    n_tx++;
    $display("tx %0d rst=%0b we=%b A=%0d:%h B=%0d:%h rd_addr=%0d,%0d", n_tx, rst, we, aa, da, ab, db,
             ra[AW-1:0], ra[2*AW-1:AW]);
    for (int d = 0; d < 2; d++) begin
      e.chk = known; e.tx = n_tx; e.rdy = rdy[d]; e.conf = conf[d];
      for (int i = 0; i < NRD; i++) e.rd[i*DW +: DW] = m_read(d, we, aa, ab, da, db, ra[i*AW +: AW]);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    // Advance the model across the coming rising edge.
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        cnt[d] = 0; rdy[d] = 1'b0; conf[d] = 1'b0;
      end else if (!rdy[d]) begin
        mem[d][cnt[d]] = '0;
        cnt[d]++;
        conf[d] = 1'b0;
        if (cnt[d] == dep(d)) rdy[d] = 1'b1;
      end else begin
        va = we[0] && m_ok(d, aa);
        vb = we[1] && m_ok(d, ab);
        if (va) mem[d][aa] = da;
        if (vb) mem[d][ab] = db;
        conf[d] = va && vb && (aa == ab);
      end
    end
    if (rst) known = 1'b1;
  endtask

  task automatic check(int d);
    exp_t e;
    logic a_rdy, a_conf;
    logic [NRD*DW-1:0] a_rd;
    if (d == 0) begin
      if (q0.size() == 0) return;
      e = q0.pop_front();
      a_rdy = if0.ready; a_conf = if0.wr_conflict; a_rd = if0.rd_data;
    end else begin
      if (q1.size() == 0) return;
      e = q1.pop_front();
      a_rdy = if1.ready; a_conf = if1.wr_conflict; a_rd = if1.rd_data;
    end
    if (!e.chk) return;
    checks++;
    if (a_rdy !== e.rdy) begin
      failures++;
      $display("FAIL ready dut%0d tx %0d got=%b exp=%b", d, e.tx, a_rdy, e.rdy);
    end
    checks++;
    if (a_conf !== e.conf) begin
      failures++;
      $display("FAIL wr_conflict dut%0d tx %0d got=%b exp=%b", d, e.tx, a_conf, e.conf);
    end
    checks++;
    if (a_rd !== e.rd) begin
      failures++;
      $display("FAIL rd_data dut%0d tx %0d got=%h exp=%h", d, e.tx, a_rd, e.rd);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      check(0);
      check(1);
    end
  end

  initial begin
    logic [1:0]    we;
    logic [AW-1:0] aa, ab, r0, r1;
    if0.wr_en = '0; if0.wr_addr = '0; if0.wr_data = '0; if0.rd_addr = '0;
    if1.wr_en = '0; if1.wr_addr = '0; if1.wr_data = '0; if1.rd_addr = '0;

    cycle(1, 2'b00, 0, 0, 0, 0, ra2(0, 1));
    cycle(1, 2'b00, 0, 0, 0, 0, ra2(5, 7));

    // Sweep: writes ignored, reads forced to zero.
    cycle(0, 2'b01, 5, 0, 32'hDEAD, 0, ra2(5, 5));
    for (int k = 1; k < 32; k++)
      cycle(0, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
            $urandom, $urandom, ra2($urandom_range(0, 31), $urandom_range(0, 31)));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(5, 5));

    for (int k = 0; k < 16; k++)
      cycle(0, 2'b11, AW'(k), AW'(k + 16), 32'(10 * k), 32'(10 * (k + 16)), ra2(k, 31 - k));
    for (int k = 0; k < 31; k++)
      cycle(0, 2'b00, 0, 0, 0, 0, ra2(k, k + 1));

    cycle(0, 2'b11, 3, 3, 7, 9, ra2(3, 3));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(3, 4));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(3, 4));

    cycle(0, 2'b01, 4, 0, 32'h55, 0, ra2(4, 4));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(4, 4));

    cycle(0, 2'b11, 25, 25, 32'hAAAA, 32'hBBBB, ra2(25, 25));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(25, 19));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(25, 0));

    for (int n = 0; n < 200; n++) begin
      we = 2'($urandom_range(0, 3));
      aa = AW'($urandom_range(0, 31));
      ab = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom_range(0, 31));
      r0 = ($urandom_range(0, 1) == 0) ? aa : AW'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 0) ? ab : AW'($urandom_range(0, 31));
      cycle(0, we, aa, ab, $urandom, $urandom, ra2(r0, r1));
    end

    cycle(0, 2'b01, 2, 0, 20, 0, ra2(2, 2));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(2, 2));
    cycle(1, 2'b00, 0, 0, 0, 0, ra2(2, 2));
    for (int k = 0; k < 32; k++) cycle(0, 2'b00, 0, 0, 0, 0, ra2(2, 3));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(2, 2));
    cycle(0, 2'b00, 0, 0, 0, 0, ra2(0, 1));

    @(negedge clk);
    #4;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain q0=%0d q1=%0d exp=0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
